// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller.
//   state_t : FSM state encodings (RUN / HOLD)
//   kind_t  : redirect source encodings (NONE / BR / JR / JMP)
//   PC_STEP : sequential fetch increment in bytes
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1
  } state_t;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_BR   = 2'd1,
    KIND_JR   = 2'd2,
    KIND_JMP  = 2'd3
  } kind_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_redirect_ctrl_jump_target_calc.sv
// Combinational relative-jump target generator.
//   jmp_field  in  26  instr[25:0] of the J/JAL
//   jmp_pc     in  32  PC of the jump instruction
//   target     out 32  (jmp_pc + 4) + (sign_extend(jmp_field) << 2), mod 2^32
module jump_target_calc
  import pc_redirect_ctrl_pkg::*;
(
  input  logic [25:0] jmp_field,
  input  logic [31:0] jmp_pc,
  output logic [31:0] target
);

  logic [31:0] offset;

  // Sign-extending to 32 bits and shifting left by 2 drops the top two
  // extension bits, so only four copies of the sign bit survive.
  assign offset = {{4{jmp_field[25]}}, jmp_field, 2'b00};
  assign target = jmp_pc + PC_STEP + offset;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer for the pipelined MIPS core.
//   Clk, Reset        clock, asynchronous active-high reset
//   stall_i           hazard stall; PC and pending state hold
//   br_req_i/target   EX-stage taken branch (highest priority)
//   jr_req_i/addr     ID-stage JR
//   jmp_req_i/field/pc ID-stage J/JAL, relative target
//   pc_o              registered PC
//   flush_ifid_o      clear IF/ID on the coming edge (combinational)
//   flush_idex_o      clear ID/EX on the coming edge (branch redirects only)
//   pending_o         a redirect is held across a stall
//   redirect_cnt_o    saturating count of applied redirects
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             stall_i,
  input  logic             br_req_i,
  input  logic [31:0]      br_target_i,
  input  logic             jr_req_i,
  input  logic [31:0]      jr_addr_i,
  input  logic             jmp_req_i,
  input  logic [25:0]      jmp_field_i,
  input  logic [31:0]      jmp_pc_i,
  output logic [31:0]      pc_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  kind_t            pend_kind_reg, pend_kind_next;
  logic [31:0]      pend_target_reg, pend_target_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [31:0] jmp_target;
  kind_t       win_kind;
  logic [31:0] win_target;
  logic        apply;
  kind_t       apply_kind;

  jump_target_calc u_jump_target_calc (
    .jmp_field (jmp_field_i),
    .jmp_pc    (jmp_pc_i),
    .target    (jmp_target)
  );

  // The EX-stage branch belongs to the older instruction, so it wins.
  always_comb begin
    win_kind   = KIND_NONE;
    win_target = '0;
    if (br_req_i) begin
      win_kind   = KIND_BR;
      win_target = br_target_i;
    end else if (jr_req_i) begin
      win_kind   = KIND_JR;
      win_target = jr_addr_i;
    end else if (jmp_req_i) begin
      win_kind   = KIND_JMP;
      win_target = jmp_target;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_kind_next   = pend_kind_reg;
    pend_target_next = pend_target_reg;
    apply            = 1'b0;
    apply_kind       = KIND_NONE;

    case (state_reg)
      ST_HOLD: begin
        if (stall_i) begin
          // A fresh branch overrides a pending ID-stage redirect, but a
          // pending branch is already the oldest and stays put.
          if (br_req_i && (pend_kind_reg != KIND_BR)) begin
            pend_kind_next   = KIND_BR;
            pend_target_next = br_target_i;
          end
        end else begin
          apply      = 1'b1;
          state_next = ST_RUN;
          if (br_req_i) begin
            apply_kind = KIND_BR;
            pc_next    = br_target_i;
          end else begin
            apply_kind = pend_kind_reg;
            pc_next    = pend_target_reg;
          end
          pend_kind_next   = KIND_NONE;
          pend_target_next = '0;
        end
      end
      default: begin
        if (!stall_i) begin
          if (win_kind != KIND_NONE) begin
            apply      = 1'b1;
            apply_kind = win_kind;
            pc_next    = win_target;
          end else begin
            pc_next = pc_reg + PC_STEP;
          end
        end else if (win_kind != KIND_NONE) begin
          pend_kind_next   = win_kind;
          pend_target_next = win_target;
          state_next       = ST_HOLD;
        end
      end
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (apply && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg       <= ST_RUN;
      pc_reg          <= RESET_PC;
      pend_kind_reg   <= KIND_NONE;
      pend_target_reg <= '0;
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_kind_reg   <= pend_kind_next;
      pend_target_reg <= pend_target_next;
      cnt_reg         <= cnt_next;
    end
  end

  assign pc_o           = pc_reg;
  assign pending_o      = (state_reg == ST_HOLD);
  assign redirect_cnt_o = cnt_reg;
  assign flush_ifid_o   = apply;
  assign flush_idex_o   = apply && (apply_kind == KIND_BR);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        stall_i, br_req_i, jr_req_i, jmp_req_i;
  logic [31:0] br_target_i, jr_addr_i, jmp_pc_i;
  logic [25:0] jmp_field_i;
  logic [31:0] pc_o;
  logic        flush_ifid_o, flush_idex_o, pending_o;
  logic [15:0] redirect_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pend;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  pc_redirect_ctrl dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .stall_i        (stall_i),
    .br_req_i       (br_req_i),
    .br_target_i    (br_target_i),
    .jr_req_i       (jr_req_i),
    .jr_addr_i      (jr_addr_i),
    .jmp_req_i      (jmp_req_i),
    .jmp_field_i    (jmp_field_i),
    .jmp_pc_i       (jmp_pc_i),
    .pc_o           (pc_o),
    .flush_ifid_o   (flush_ifid_o),
    .flush_idex_o   (flush_idex_o),
    .pending_o      (pending_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    stall_i = 0; br_req_i = 0; jr_req_i = 0; jmp_req_i = 0;
    br_target_i = 0; jr_addr_i = 0; jmp_field_i = 0; jmp_pc_i = 0;
  endtask

  // One transaction: drive inputs, check combinational flushes before the
  // edge, queue the registered expectation, compare it after the edge.
  task automatic step(input string tag,
                      input logic st, input logic br, input logic [31:0] bt,
                      input logic jr, input logic [31:0] ja,
                      input logic jm, input logic [25:0] jf, input logic [31:0] jp,
                      input logic e_ifid, input logic e_idex,
                      input logic [31:0] e_pc, input logic e_pend, input logic [15:0] e_cnt);
    exp_t e;
    exp_t got;
    stall_i = st; br_req_i = br; br_target_i = bt;
    jr_req_i = jr; jr_addr_i = ja;
    jmp_req_i = jm; jmp_field_i = jf; jmp_pc_i = jp;
    e.tag = tag; e.pc = e_pc; e.pend = e_pend; e.cnt = e_cnt;
    exp_q.push_back(e);
    @(negedge Clk);
    chk({tag, ".flush_ifid"}, {31'd0, flush_ifid_o}, {31'd0, e_ifid});
    chk({tag, ".flush_idex"}, {31'd0, flush_idex_o}, {31'd0, e_idex});
    @(posedge Clk);
    #1;
    got = exp_q.pop_front();
    chk({got.tag, ".pc"},      pc_o,                   got.pc);
    chk({got.tag, ".pending"}, {31'd0, pending_o},     {31'd0, got.pend});
    chk({got.tag, ".cnt"},     {16'd0, redirect_cnt_o}, {16'd0, got.cnt});
    $display("step %-12s pc=0x%08h ifid=%0b idex=%0b pend=%0b cnt=%0d",
             tag, pc_o, flush_ifid_o, flush_idex_o, pending_o, redirect_cnt_o);
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst.pc", pc_o, 32'h0);
    chk("rst.pending", {31'd0, pending_o}, 32'd0);
    chk("rst.cnt", {16'd0, redirect_cnt_o}, 32'd0);
    chk("rst.flush_ifid", {31'd0, flush_ifid_o}, 32'd0);
    chk("rst.flush_idex", {31'd0, flush_idex_o}, 32'd0);
    Reset = 1'b0;

    //    tag         st br bt          jr ja           jm jf            jp          ifid idex pc            pend cnt
    step("seq1",      0, 0, 0,          0, 0,           0, 26'h0,        0,          0, 0, 32'h4,        0, 0);
    step("seq2",      0, 0, 0,          0, 0,           0, 26'h0,        0,          0, 0, 32'h8,        0, 0);
    step("seq3",      0, 0, 0,          0, 0,           0, 26'h0,        0,          0, 0, 32'hC,        0, 0);
    step("jmp_pos",   0, 0, 0,          0, 0,           1, 26'h0000010,  32'h100,    1, 0, 32'h144,      0, 1);
    step("jmp_neg",   0, 0, 0,          0, 0,           1, 26'h3FFFFFF,  32'h100,    1, 0, 32'h100,      0, 2);
    step("jmp_wrap",  0, 0, 0,          0, 0,           1, 26'h2000000,  32'h0,      1, 0, 32'hF8000004, 0, 3);
    step("br_vs_jmp", 0, 1, 32'h400,    0, 0,           1, 26'h10,       32'h100,    1, 1, 32'h400,      0, 4);
    step("jr_vs_jmp", 0, 0, 0,          1, 32'h1234,    1, 26'h10,       32'h100,    1, 0, 32'h1234,     0, 5);
    step("seq4",      0, 0, 0,          0, 0,           0, 26'h0,        0,          0, 0, 32'h1238,     0, 5);
    // Jump from 0x1FC with a zero field targets 0x200.
    step("hold_jmp",  1, 0, 0,          0, 0,           1, 26'h0,        32'h1FC,    0, 0, 32'h1238,     1, 5);
    step("hold_br",   1, 1, 32'h80,     0, 0,           0, 26'h0,        0,          0, 0, 32'h1238,     1, 5);
    step("hold_keep", 1, 1, 32'h90,     1, 32'h700,     1, 26'h5,        32'h0,      0, 0, 32'h1238,     1, 5);
    step("apply_br",  0, 0, 0,          0, 0,           0, 26'h0,        0,          1, 1, 32'h80,       0, 6);
    step("hold_jr",   1, 0, 0,          1, 32'h300,     0, 26'h0,        0,          0, 0, 32'h80,       1, 6);
    step("hold_ign",  1, 0, 0,          1, 32'h999,     1, 26'h7,        32'h40,     0, 0, 32'h80,       1, 6);
    step("apply_jr",  0, 0, 0,          0, 0,           0, 26'h0,        0,          1, 0, 32'h300,      0, 7);
    step("hold_jmp2", 1, 0, 0,          0, 0,           1, 26'h0,        32'h1FC,    0, 0, 32'h300,      1, 7);
    step("apply_fbr", 0, 1, 32'h500,    0, 0,           0, 26'h0,        0,          1, 1, 32'h500,      0, 8);
    step("hold_jmp3", 1, 0, 0,          0, 0,           1, 26'h0,        32'h1FC,    0, 0, 32'h500,      1, 8);

    // Asynchronous reset in HOLD takes effect without a clock edge.
    idle_inputs();
    #2;
    Reset = 1'b1;
    #1;
    chk("arst.pc", pc_o, 32'h0);
    chk("arst.pending", {31'd0, pending_o}, 32'd0);
    chk("arst.cnt", {16'd0, redirect_cnt_o}, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    step("post_rst",  0, 0, 0,          0, 0,           0, 26'h0,        0,          0, 0, 32'h4,        0, 0);

    // Drive the counter to its ceiling with back-to-back JR redirects.
    stall_i = 0; jr_req_i = 1; jr_addr_i = 32'h2000;
    repeat (65535) @(posedge Clk);
    #1;
    chk("sat.reach", {16'd0, redirect_cnt_o}, 32'hFFFF);
    step("sat_hold",  0, 0, 0,          1, 32'h3000,    0, 26'h0,        0,          1, 0, 32'h3000,     0, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
